// File: rtl/norflash_arbiter.sv
// norflash_arbiter: round-robin arbiter sharing one norflash_ctrl port between two requesters,
// with reserved-command rejection and a watchdog timeout on the controller handshake.
module norflash_arbiter #(
    parameter int ASIZE   = 22,
    parameter int DSIZE   = 8,
    parameter int TO_W    = 26,
    parameter int TIMEOUT = 50000000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [2:0]       cmd0_i,
    input  logic [2:0]       cmd1_i,
    input  logic [ASIZE-1:0] addr0_i,
    input  logic [ASIZE-1:0] addr1_i,
    input  logic [DSIZE-1:0] wdata0_i,
    input  logic [DSIZE-1:0] wdata1_i,
    output logic             ack0_o,
    output logic             ack1_o,
    output logic             err0_o,
    output logic             err1_o,
    output logic [DSIZE-1:0] rdata0_o,
    output logic [DSIZE-1:0] rdata1_o,
    output logic             flash_req_o,
    output logic [2:0]       sys_cmd_o,
    output logic [ASIZE-1:0] sys_rd_addr_o,
    output logic [ASIZE-1:0] sys_wr_addr_o,
    output logic [DSIZE-1:0] sys_wr_data_o,
    input  logic             flash_ack_i,
    input  logic [DSIZE-1:0] sys_data_i,
    output logic             busy_o,
    output logic             grant_o
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_REJECT} state_t;

    localparam logic [TO_W-1:0] LP_LIMIT = TO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t           r_state, w_next;
    logic             r_last, r_grant, r_err;
    logic [TO_W-1:0]  r_cnt;
    logic [2:0]       r_cmd;
    logic [ASIZE-1:0] r_addr;
    logic [DSIZE-1:0] r_wdata, r_rdata0, r_rdata1;
    logic             w_any, w_win, w_rsv, w_expire, w_fin;
    logic [2:0]       w_cmd;

    assign w_any    = req0_i | req1_i;
    // on a tie the requester that did not win last time goes first
    assign w_win    = (req0_i & req1_i) ? ~r_last : req1_i;
    assign w_cmd    = w_win ? cmd1_i : cmd0_i;
    assign w_rsv    = (w_cmd == 3'd0) || (w_cmd > 3'd4);
    assign w_expire = (TIMEOUT != 0) && (r_cnt == LP_LIMIT);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_any ? (w_rsv ? S_REJECT : S_REQ) : S_IDLE;
            S_REQ:    w_next = S_WAIT;
            S_WAIT:   w_next = (flash_ack_i || w_expire) ? S_DONE : S_WAIT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_last   <= 1'b1;
            r_grant  <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_cmd    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_grant <= w_win;
                r_last  <= w_win;
                r_cmd   <= w_cmd;
                r_addr  <= w_win ? addr1_i : addr0_i;
                r_wdata <= w_win ? wdata1_i : wdata0_i;
                r_err   <= 1'b0;
            end
            if (r_state == S_REQ) r_cnt <= '0;
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + TO_W'(1);
                // an ack arriving on the expiry cycle still counts as success
                if (flash_ack_i) begin
                    r_err <= 1'b0;
                    if (r_cmd == 3'd1 && !r_grant) r_rdata0 <= sys_data_i;
                    if (r_cmd == 3'd1 &&  r_grant) r_rdata1 <= sys_data_i;
                end else if (w_expire) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_fin       = (r_state == S_DONE) || (r_state == S_REJECT);
        flash_req_o = (r_state == S_REQ) || (r_state == S_WAIT);
        busy_o      = r_state != S_IDLE;
        ack0_o      = w_fin & ~r_grant;
        ack1_o      = w_fin & r_grant;
        err0_o      = ack0_o & ((r_state == S_REJECT) | r_err);
        err1_o      = ack1_o & ((r_state == S_REJECT) | r_err);
    end

    assign grant_o       = r_grant;
    assign sys_cmd_o     = r_cmd;
    assign sys_rd_addr_o = r_addr;
    assign sys_wr_addr_o = r_addr;
    assign sys_wr_data_o = r_wdata;
    assign rdata0_o      = r_rdata0;
    assign rdata1_o      = r_rdata1;
endmodule

// File: tb/tb_norflash_arbiter.sv
// tb_norflash_arbiter: table-driven vectors plus directed multi-cycle sequences
// for the norflash_arbiter (TIMEOUT shortened to 16 cycles).
module tb_norflash_arbiter;
    logic        sys_clk, sys_rst;
    logic        req0_i, req1_i;
    logic [2:0]  cmd0_i, cmd1_i;
    logic [21:0] addr0_i, addr1_i;
    logic [7:0]  wdata0_i, wdata1_i;
    logic        ack0_o, ack1_o, err0_o, err1_o;
    logic [7:0]  rdata0_o, rdata1_o;
    logic        flash_req_o;
    logic [2:0]  sys_cmd_o;
    logic [21:0] sys_rd_addr_o, sys_wr_addr_o;
    logic [7:0]  sys_wr_data_o;
    logic        flash_ack_i;
    logic [7:0]  sys_data_i;
    logic        busy_o, grant_o;

    int checks = 0;
    int failures = 0;

    norflash_arbiter #(.ASIZE(22), .DSIZE(8), .TO_W(26), .TIMEOUT(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req0_i(req0_i), .req1_i(req1_i), .cmd0_i(cmd0_i), .cmd1_i(cmd1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .ack0_o(ack0_o), .ack1_o(ack1_o), .err0_o(err0_o), .err1_o(err1_o),
        .rdata0_o(rdata0_o), .rdata1_o(rdata1_o), .flash_req_o(flash_req_o),
        .sys_cmd_o(sys_cmd_o), .sys_rd_addr_o(sys_rd_addr_o), .sys_wr_addr_o(sys_wr_addr_o),
        .sys_wr_data_o(sys_wr_data_o), .flash_ack_i(flash_ack_i), .sys_data_i(sys_data_i),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic        r0, r1;
        logic [2:0]  c0, c1;
        logic [21:0] a0, a1;
        logic [7:0]  w0, w1;
        logic        fa;
        logic [7:0]  sd;
        logic [22:0] exp; // {flash_req, busy, ack0, ack1, err0, err1, grant, rdata0, rdata1}
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [22:0] outs();
        return {flash_req_o, busy_o, ack0_o, ack1_o, err0_o, err1_o, grant_o, rdata0_o, rdata1_o};
    endfunction

    task automatic do_reset();
        sys_rst = 1'b1;
        req0_i = 0; req1_i = 0; cmd0_i = 0; cmd1_i = 0;
        addr0_i = 0; addr1_i = 0; wdata0_i = 0; wdata1_i = 0;
        flash_ack_i = 0; sys_data_i = 0;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic wait_freq(input string name);
        int n = 0;
        while (!flash_req_o && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'd0, flash_req_o}, 32'd1);
    endtask

    initial begin
        tbl[0]  = '{1, 0, 3'd1, 3'd0, 22'h123, 22'h0,  8'h0, 8'h0, 0, 8'h00, {7'b1100000, 8'h00, 8'h00}};
        for (int i = 1; i <= 5; i++)
            tbl[i] = '{1, 0, 3'd1, 3'd0, 22'h123, 22'h0, 8'h0, 8'h0, 0, 8'h00, {7'b1100000, 8'h00, 8'h00}};
        tbl[6]  = '{1, 0, 3'd1, 3'd0, 22'h123, 22'h0,  8'h0, 8'h0, 1, 8'hA5, {7'b0110000, 8'hA5, 8'h00}};
        tbl[7]  = '{0, 0, 3'd0, 3'd0, 22'h0,   22'h0,  8'h0, 8'h0, 1, 8'h11, {7'b0000000, 8'hA5, 8'h00}};
        tbl[8]  = '{0, 1, 3'd0, 3'd6, 22'h0,   22'h20, 8'h0, 8'h0, 0, 8'h00, {7'b0101011, 8'hA5, 8'h00}};
        tbl[9]  = '{0, 0, 3'd0, 3'd0, 22'h0,   22'h0,  8'h0, 8'h0, 0, 8'h00, {7'b0000001, 8'hA5, 8'h00}};
        tbl[10] = '{0, 0, 3'd0, 3'd0, 22'h0,   22'h0,  8'h0, 8'h0, 1, 8'hFF, {7'b0000001, 8'hA5, 8'h00}};

        do_reset();
        chk("reset_outs", {9'd0, outs()}, 32'd0);
        chk("reset_sys", {sys_cmd_o, sys_rd_addr_o, sys_wr_data_o}, 32'd0);

        // single read from requester 0, then reserved command from requester 1
        for (int i = 0; i < 11; i++) begin
            req0_i = tbl[i].r0; req1_i = tbl[i].r1;
            cmd0_i = tbl[i].c0; cmd1_i = tbl[i].c1;
            addr0_i = tbl[i].a0; addr1_i = tbl[i].a1;
            wdata0_i = tbl[i].w0; wdata1_i = tbl[i].w1;
            flash_ack_i = tbl[i].fa; sys_data_i = tbl[i].sd;
            tick();
            chk($sformatf("vec[%0d]", i), {9'd0, outs()}, {9'd0, tbl[i].exp});
            if (i == 0) begin
                chk("read_addr", {10'd0, sys_rd_addr_o}, 32'h123);
                chk("read_waddr", {10'd0, sys_wr_addr_o}, 32'h123);
                chk("read_cmd", {29'd0, sys_cmd_o}, 32'd1);
            end
        end

        // reset in the middle of WAIT
        do_reset();
        req0_i = 1; cmd0_i = 3'd1; addr0_i = 22'h77;
        tick();
        tick();
        chk("rst_wait_pre", {30'd0, flash_req_o, busy_o}, 32'd3);
        sys_rst = 1;
        tick();
        sys_rst = 0; req0_i = 0;
        chk("rst_wait_post", {28'd0, flash_req_o, busy_o, ack0_o, ack1_o}, 32'd0);
        tick();
        chk("rst_wait_idle", {28'd0, flash_req_o, busy_o, ack0_o, ack1_o}, 32'd0);

        // simultaneous requests, both held: grants alternate 0,1,0,1
        do_reset();
        req0_i = 1; cmd0_i = 3'd2; addr0_i = 22'h10; wdata0_i = 8'h55;
        req1_i = 1; cmd1_i = 3'd1; addr1_i = 22'h20;
        for (int g = 0; g < 4; g++) begin
            wait_freq($sformatf("rr_freq[%0d]", g));
            chk($sformatf("rr_grant[%0d]", g), {31'd0, grant_o}, g % 2);
            if (g == 0) begin
                chk("rr_wdata", {24'd0, sys_wr_data_o}, 32'h55);
                chk("rr_addr0", {10'd0, sys_wr_addr_o}, 32'h10);
            end
            if (g == 1) chk("rr_addr1", {10'd0, sys_rd_addr_o}, 32'h20);
            tick();
            flash_ack_i = 1; sys_data_i = 8'h30 + 8'(g);
            tick();
            flash_ack_i = 0;
            chk($sformatf("rr_ack[%0d]", g), {30'd0, ack0_o, ack1_o}, (g % 2) ? 32'd1 : 32'd2);
        end
        chk("rr_rdata1", {24'd0, rdata1_o}, 32'h33);
        chk("rr_rdata0", {24'd0, rdata0_o}, 32'h00);

        // timeout: controller never acks
        do_reset();
        req0_i = 1; cmd0_i = 3'd1; addr0_i = 22'h5;
        tick();
        begin
            int hi = 0;
            while (flash_req_o && hi < 40) begin
                hi++;
                tick();
            end
            chk("to_len", hi, 32'd17);
        end
        chk("to_ack", {28'd0, flash_req_o, ack0_o, err0_o, ack1_o}, 32'b0110);
        chk("to_rdata", {24'd0, rdata0_o}, 32'h00);
        req0_i = 0;
        tick();

        // back-to-back: re-request in M+2, stray ack in IDLE
        do_reset();
        req0_i = 1; cmd0_i = 3'd1; addr0_i = 22'h40;
        tick();
        tick();
        flash_ack_i = 1; sys_data_i = 8'h77;
        tick();
        flash_ack_i = 0; req0_i = 0;
        chk("b2b_ack1", {29'd0, ack0_o, err0_o, flash_req_o}, 32'b100);
        chk("b2b_rdata", {24'd0, rdata0_o}, 32'h77);
        tick();
        req0_i = 1; cmd0_i = 3'd3; addr0_i = 22'h50; flash_ack_i = 1; sys_data_i = 8'hEE;
        tick();
        flash_ack_i = 0;
        chk("b2b_freq", {31'd0, flash_req_o}, 32'd1);
        chk("b2b_sys", {7'd0, sys_cmd_o, sys_rd_addr_o}, {7'd0, 3'd3, 22'h50});
        tick();
        tick();
        chk("b2b_wait", {29'd0, flash_req_o, busy_o, ack0_o}, 32'b110);
        flash_ack_i = 1; sys_data_i = 8'h99;
        tick();
        flash_ack_i = 0; req0_i = 0;
        chk("b2b_ack2", {29'd0, ack0_o, err0_o, ack1_o}, 32'b100);
        chk("b2b_keep", {24'd0, rdata0_o}, 32'h77);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
